// File: rtl/m_alu_core_arb_if.sv
// Shared types and the requester/consumer bundle for the shared ALU arbiter.
// The package sits here so that it is compiled ahead of every module that uses it.
package m_alu_core_arb_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_SRA = 4'd7
    } e_core_op;

    typedef enum logic [1:0] {
        CMP_RES_EQ = 2'd0,
        CMP_RES_LT = 2'd1,
        CMP_RES_GT = 2'd2
    } e_cmp_res;
endpackage

interface m_alu_core_arb_if
    import m_alu_core_arb_pkg::*;
#(
    parameter int N_REQ = 2
);
    localparam int ID_W = $clog2(N_REQ);

    logic     [N_REQ-1:0]       req_valid;
    logic     [N_REQ-1:0]       req_lock;
    e_core_op [N_REQ-1:0]       req_op;
    logic     [N_REQ-1:0][31:0] req_a;
    logic     [N_REQ-1:0][31:0] req_b;
    logic     [N_REQ-1:0]       req_ready;
    logic                       res_valid;
    logic                       res_ready;
    logic     [31:0]            res_data;
    e_cmp_res                   res_cmp;
    logic     [ID_W-1:0]        res_id;
    logic                       locked;

    modport master (
        output req_valid, req_lock, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_cmp, res_id, locked
    );

    modport slave (
        input  req_valid, req_lock, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_cmp, res_id, locked
    );
endinterface

// File: rtl/m_alu_core_arb.sv
// One combinational ALU core shared by N_REQ requesters: round-robin grant with an
// optional lock, single-entry registered result stage with valid/ready backpressure.
module m_alu_core_op
    import m_alu_core_arb_pkg::*;
(
    input  e_core_op    op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output e_cmp_res    cmp
);
    always_comb begin
        out = 32'hffff_ffff;
        case (op)
            OP_ADD:  out = a + b;
            OP_SUB:  out = a - b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_SHL:  out = a << b[4:0];
            OP_SHR:  out = a >> b[4:0];
            OP_SRA:  out = $unsigned($signed(a) >>> b[4:0]);
            default: out = 32'hffff_ffff;
        endcase
        // Unsigned magnitude compare of the same operands.
        if (a == b)     cmp = CMP_RES_EQ;
        else if (a < b) cmp = CMP_RES_LT;
        else            cmp = CMP_RES_GT;
    end
endmodule

module m_alu_core_arb
    import m_alu_core_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input logic              clk,
    input logic              rst,
    m_alu_core_arb_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {LK_IDLE, LK_HELD} e_lock_st;

    e_lock_st          lock_st_q, lock_st_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    e_cmp_res          res_cmp_q, res_cmp_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;

    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   scan_id;
    logic              accept_ok;
    logic              xfer;
    e_core_op          core_op;
    logic [31:0]       core_a, core_b, core_out;
    e_cmp_res          core_cmp;

    // Scan from farthest to nearest so the last hit is the closest after last_grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan_id = '0;
        if (lock_st_q == LK_HELD) begin
            gnt_vld = bus.req_valid[lock_id_q];
            gnt_id  = lock_id_q;
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                scan_id = ID_W'((int'(last_grant_q) + k) % N_REQ);
                if (bus.req_valid[scan_id]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan_id;
                end
            end
        end
    end

    assign accept_ok = !res_valid_q || bus.res_ready;
    assign xfer      = gnt_vld && accept_ok && !rst;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            bus.req_ready[i] = xfer && (gnt_id == ID_W'(i));
    end

    assign core_op = bus.req_op[gnt_id];
    assign core_a  = bus.req_a[gnt_id];
    assign core_b  = bus.req_b[gnt_id];

    m_alu_core_op u_core (
        .op  (core_op),
        .a   (core_a),
        .b   (core_b),
        .out (core_out),
        .cmp (core_cmp)
    );

    always_comb begin
        lock_st_d    = lock_st_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_cmp_d    = res_cmp_q;
        res_id_d     = res_id_q;

        if (xfer) begin
            res_valid_d  = 1'b1;
            res_data_d   = core_out;
            res_cmp_d    = core_cmp;
            res_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        case (lock_st_q)
            LK_IDLE: if (xfer && bus.req_lock[gnt_id]) begin
                lock_st_d = LK_HELD;
                lock_id_d = gnt_id;
            end
            LK_HELD: if (xfer && !bus.req_lock[gnt_id]) lock_st_d = LK_IDLE;
            default: lock_st_d = LK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_st_q    <= LK_IDLE;
            lock_id_q    <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cmp_q    <= CMP_RES_EQ;
            res_id_q     <= '0;
        end else begin
            lock_st_q    <= lock_st_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_cmp_q    <= res_cmp_d;
            res_id_q     <= res_id_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_cmp   = res_cmp_q;
    assign bus.res_id    = res_id_q;
    assign bus.locked    = (lock_st_q == LK_HELD);
endmodule

// File: tb/tb_m_alu_core_arb.sv
// Directed bench for m_alu_core_arb: a transaction-level reference model checked on
// every falling edge, plus hand-computed literal expectations for each scenario.
module tb_m_alu_core_arb;
    import m_alu_core_arb_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    m_alu_core_arb_if #(.N_REQ(N)) bus ();

    m_alu_core_arb #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_out(input e_core_op op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a * (32'd1 << sh);
            OP_SHR:  return a / (32'd1 << sh);
            OP_SRA:  return (a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh));
            default: return 32'hffff_ffff;
        endcase
    endfunction

    function automatic e_cmp_res ref_cmp(input logic [31:0] a, input logic [31:0] b);
        if (a == b) return CMP_RES_EQ;
        return (a < b) ? CMP_RES_LT : CMP_RES_GT;
    endfunction

    // Reference model: output register contents, lock ownership and rotating pointer.
    logic        m_valid;
    logic [31:0] m_data;
    e_cmp_res    m_cmp;
    int          m_id, m_last, m_lock_id;
    logic        m_locked;

    always @(negedge clk) begin
        int  g;
        logic gv, acc;
        logic [N-1:0] exp_rdy;
        if (rst) begin
            m_valid = 0; m_data = 0; m_cmp = CMP_RES_EQ; m_id = 0;
            m_last = N - 1; m_locked = 0; m_lock_id = 0;
            chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
            chk("rst_locked", 32'(bus.locked), 32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end else begin
            chk("m_res_valid", 32'(bus.res_valid), 32'(m_valid));
            chk("m_res_data", bus.res_data, m_data);
            chk("m_res_cmp", 32'(bus.res_cmp), 32'(m_cmp));
            chk("m_res_id", 32'(bus.res_id), 32'(m_id));
            chk("m_locked", 32'(bus.locked), 32'(m_locked));

            acc = !m_valid || bus.res_ready;
            gv = 0; g = 0;
            if (m_locked) begin
                g = m_lock_id; gv = bus.req_valid[g];
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!gv && bus.req_valid[(m_last + k) % N]) begin
                        gv = 1; g = (m_last + k) % N;
                    end
                end
            end
            exp_rdy = (gv && acc) ? N'(1 << g) : '0;
            chk("m_req_ready", 32'(bus.req_ready), 32'(exp_rdy));

            if (gv && acc) begin
                m_data  = ref_out(bus.req_op[g], bus.req_a[g], bus.req_b[g]);
                m_cmp   = ref_cmp(bus.req_a[g], bus.req_b[g]);
                m_id    = g;
                m_valid = 1;
                m_last  = g;
                if (!m_locked && bus.req_lock[g]) begin
                    m_locked = 1; m_lock_id = g;
                end else if (m_locked && !bus.req_lock[g]) begin
                    m_locked = 0;
                end
            end else if (bus.res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic lk, input e_core_op op,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i] = v;
        bus.req_lock[i]  = lk;
        bus.req_op[i]    = op;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_op    = '{default: OP_ADD};
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // 1: single request, 5+7
        set_req(0, 1, 0, OP_ADD, 32'd5, 32'd7);
        #1;
        chk("t1_req_ready", 32'(bus.req_ready), 32'b01);
        step();
        chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_res_data", bus.res_data, 32'd12);
        chk("t1_res_cmp", 32'(bus.res_cmp), 32'(CMP_RES_LT));
        chk("t1_res_id", 32'(bus.res_id), 32'd0);

        // 2: both valid, alternating grants starting with 1
        set_req(0, 1, 0, OP_ADD, 32'd1, 32'd1);
        set_req(1, 1, 0, OP_SUB, 32'd10, 32'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
            chk("t2_res_id", 32'(bus.res_id), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_res_data", bus.res_data, (i % 2 == 0) ? 32'd7 : 32'd2);
        end

        // 3: backpressure holds result and stalls both requesters
        bus.res_ready = 1'b0;
        #1;
        chk("t3_req_ready_stall", 32'(bus.req_ready), 32'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_data", bus.res_data, 32'd2);
            chk("t3_hold_id", 32'(bus.res_id), 32'd0);
            chk("t3_hold_valid", 32'(bus.res_valid), 32'd1);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("t3_req_ready_go", 32'(bus.req_ready), 32'b10);
        step();
        chk("t3_res_data", bus.res_data, 32'd7);
        chk("t3_res_id", 32'(bus.res_id), 32'd1);

        // 4: requester 1 holds the lock for three transfers
        bus.req_valid = 2'b01;
        step();
        chk("t4_pre_id", 32'(bus.res_id), 32'd0);
        set_req(1, 1, 1, OP_ADD, 32'd1, 32'd1);
        #1;
        chk("t4_ready_a", 32'(bus.req_ready), 32'b10);
        step();
        chk("t4_add", bus.res_data, 32'd2);
        chk("t4_add_id", 32'(bus.res_id), 32'd1);
        chk("t4_locked", 32'(bus.locked), 32'd1);
        bus.req_valid[1] = 1'b0;
        #1;
        chk("t4_held_idle_ready", 32'(bus.req_ready), 32'b00);
        step();
        chk("t4_held_locked", 32'(bus.locked), 32'd1);
        chk("t4_drained", 32'(bus.res_valid), 32'd0);
        set_req(1, 1, 1, OP_SHL, 32'd1, 32'd4);
        step();
        chk("t4_shl", bus.res_data, 32'd16);
        chk("t4_shl_id", 32'(bus.res_id), 32'd1);
        set_req(1, 1, 0, OP_XOR, 32'hff, 32'h0f);
        step();
        chk("t4_xor", bus.res_data, 32'hf0);
        chk("t4_xor_id", 32'(bus.res_id), 32'd1);
        chk("t4_unlocked", 32'(bus.locked), 32'd0);
        set_req(0, 1, 0, e_core_op'(4'hf), 32'd3, 32'd9);
        #1;
        chk("t4_next_ready", 32'(bus.req_ready), 32'b01);
        step();
        chk("t4_default_op", bus.res_data, 32'hffff_ffff);
        chk("t4_default_id", 32'(bus.res_id), 32'd0);
        chk("t4_default_cmp", 32'(bus.res_cmp), 32'(CMP_RES_LT));

        // 5: reset while locked with a result pending
        set_req(0, 1, 0, OP_ADD, 32'd2, 32'd2);
        set_req(1, 1, 1, OP_ADD, 32'd1, 32'd1);
        step();
        chk("t5_pre_locked", 32'(bus.locked), 32'd1);
        chk("t5_pre_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("t5_rst_locked", 32'(bus.locked), 32'd0);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'b00);
        chk("t5_rst_data", bus.res_data, 32'd0);
        step();
        rst = 1'b0;
        bus.req_lock = '0;
        #1;
        chk("t5_tie_ready", 32'(bus.req_ready), 32'b01);
        step();
        chk("t5_tie_id", 32'(bus.res_id), 32'd0);
        chk("t5_tie_data", bus.res_data, 32'd4);
        chk("t5_tie_cmp", 32'(bus.res_cmp), 32'(CMP_RES_EQ));

        bus.req_valid = '0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end
endmodule
